// File: rtl/bch_serial_decoder_15_7_if.sv
// Handshake and result bundle for the serial BCH(15,7) decoder.
// master: bit source / result consumer; slave: the decoder itself.
interface bch_serial_decoder_15_7_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_msg;
  logic [1:0] out_err_cnt;
  logic       out_uncorrectable;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_msg, out_err_cnt, out_uncorrectable
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_msg, out_err_cnt, out_uncorrectable
  );
endinterface

// File: rtl/bch_serial_decoder_15_7.sv
// Serial BCH(15,7,2) decoder over GF(16) (x^4+x+1).
// Bits arrive c14 first; syndromes S1=r(alpha), S3=r(alpha^3) are built in
// Horner form, the error locator is formed in one cycle (Peterson, t=2),
// then a 15-cycle Chien search flips the located bits. Latency from the
// last accepted bit to out_valid is a fixed 17 cycles.
module bch_serial_decoder_15_7 (
  input logic                      clk,
  input logic                      rst,
  bch_serial_decoder_15_7_if.slave bus
);

  localparam logic [1:0] ST_RECV  = 2'd0;
  localparam logic [1:0] ST_SIGMA = 2'd1;
  localparam logic [1:0] ST_CHIEN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ---------------------------------------------------------------------------
  // GF(16) helpers (log/antilog based; zero operands short-circuit so the
  // undefined log of 0 never enters the exponent arithmetic)
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] gf_alog(input logic [3:0] e);
    logic [3:0] r;
    case (e)
      4'd0:    r = 4'd1;
      4'd1:    r = 4'd2;
      4'd2:    r = 4'd4;
      4'd3:    r = 4'd8;
      4'd4:    r = 4'd3;
      4'd5:    r = 4'd6;
      4'd6:    r = 4'd12;
      4'd7:    r = 4'd11;
      4'd8:    r = 4'd5;
      4'd9:    r = 4'd10;
      4'd10:   r = 4'd7;
      4'd11:   r = 4'd14;
      4'd12:   r = 4'd15;
      4'd13:   r = 4'd13;
      4'd14:   r = 4'd9;
      default: r = 4'd1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] gf_log(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'd1:    r = 4'd0;
      4'd2:    r = 4'd1;
      4'd4:    r = 4'd2;
      4'd8:    r = 4'd3;
      4'd3:    r = 4'd4;
      4'd6:    r = 4'd5;
      4'd12:   r = 4'd6;
      4'd11:   r = 4'd7;
      4'd5:    r = 4'd8;
      4'd10:   r = 4'd9;
      4'd7:    r = 4'd10;
      4'd14:   r = 4'd11;
      4'd15:   r = 4'd12;
      4'd13:   r = 4'd13;
      4'd9:    r = 4'd14;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Reduce an exponent sum (0..28) modulo 15.
  function automatic logic [3:0] gf_exp_mod(input logic [4:0] s);
    logic [3:0] r;
    if (s >= 5'd15) begin
      r = 4'(s - 5'd15);
    end else begin
      r = s[3:0];
    end
    return r;
  endfunction

  // a * alpha^e
  function automatic logic [3:0] gf_scale(input logic [3:0] a, input logic [3:0] e);
    logic [3:0] r;
    if (a == 4'd0) begin
      r = 4'd0;
    end else begin
      r = gf_alog(gf_exp_mod({1'b0, gf_log(a)} + {1'b0, e}));
    end
    return r;
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    if ((a == 4'd0) || (b == 4'd0)) begin
      r = 4'd0;
    end else begin
      r = gf_alog(gf_exp_mod({1'b0, gf_log(a)} + {1'b0, gf_log(b)}));
    end
    return r;
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] r;
    logic [3:0] l;
    l = gf_log(a);
    if (a == 4'd0) begin
      r = 4'd0;
    end else if (l == 4'd0) begin
      r = 4'd1;
    end else begin
      r = gf_alog(4'(5'd15 - {1'b0, l}));
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]  state_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  s1_r;
  logic [3:0]  s3_r;
  logic [14:0] word_r;
  logic [6:0]  raw_msg_r;
  logic [3:0]  sigma1_r;
  logic [3:0]  sigma2_r;
  logic [1:0]  exp_deg_r;
  logic        fail_flag_r;
  logic [3:0]  chien_cnt_r;
  logic [1:0]  root_cnt_r;
  logic [6:0]  out_msg_r;
  logic [1:0]  out_err_cnt_r;
  logic        out_unc_r;

  // Combinational terms
  logic [1:0]  next_state_s;
  logic        accept_s;
  logic [3:0]  s1_cube_s;
  logic [3:0]  syn_sum_s;
  logic [3:0]  sigma2_s;
  logic [1:0]  exp_deg_s;
  logic        fail_flag_s;
  logic [3:0]  neg_j_s;
  logic [3:0]  two_j_s;
  logic [3:0]  neg_2j_s;
  logic [3:0]  loc_val_s;
  logic        root_s;
  logic [14:0] word_fix_s;
  logic [1:0]  root_cnt_next_s;
  logic        unc_s;

  assign accept_s = bus.in_valid & in_ready_r;

  // Next-state decode of the RECV -> SIGMA -> CHIEN -> DONE sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RECV: begin
        if (accept_s && (bit_cnt_r == 4'd14)) begin
          next_state_s = ST_SIGMA;
        end else begin
          next_state_s = ST_RECV;
        end
      end
      ST_SIGMA: next_state_s = ST_CHIEN;
      ST_CHIEN: begin
        if (chien_cnt_r == 4'd14) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_CHIEN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_RECV;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_RECV;
    endcase
  end

  // Error-locator coefficients and expected degree from the syndromes.
  always_comb begin
    s1_cube_s = gf_mul(s1_r, gf_mul(s1_r, s1_r));
    syn_sum_s = s3_r ^ s1_cube_s;
    sigma2_s  = 4'd0;
    exp_deg_s = 2'd0;
    fail_flag_s = 1'b0;
    if (s1_r != 4'd0) begin
      sigma2_s = gf_mul(syn_sum_s, gf_inv(s1_r));
      if (syn_sum_s == 4'd0) begin
        exp_deg_s = 2'd1;
      end else begin
        exp_deg_s = 2'd2;
      end
    end else begin
      exp_deg_s   = 2'd0;
      fail_flag_s = (s3_r != 4'd0);
    end
  end

  // Chien step j: evaluate L(alpha^-j) and derive the corrected word/count.
  always_comb begin
    neg_j_s  = (chien_cnt_r == 4'd0) ? 4'd0 : 4'(5'd15 - {1'b0, chien_cnt_r});
    two_j_s  = gf_exp_mod({chien_cnt_r, 1'b0});
    neg_2j_s = (two_j_s == 4'd0) ? 4'd0 : 4'(5'd15 - {1'b0, two_j_s});
    loc_val_s = 4'd1 ^ gf_scale(sigma1_r, neg_j_s) ^ gf_scale(sigma2_r, neg_2j_s);
    root_s = (loc_val_s == 4'd0);
    if (root_s) begin
      word_fix_s = word_r ^ (15'd1 << chien_cnt_r);
      root_cnt_next_s = (root_cnt_r == 2'd3) ? 2'd3 : (root_cnt_r + 2'd1);
    end else begin
      word_fix_s = word_r;
      root_cnt_next_s = root_cnt_r;
    end
    unc_s = fail_flag_r | (root_cnt_next_s != exp_deg_r);
  end

  // State register with the handshake flags registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RECV;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == ST_RECV);
      out_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Syndrome accumulation, locator capture, Chien correction and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r     <= 4'd0;
      s1_r          <= 4'd0;
      s3_r          <= 4'd0;
      word_r        <= 15'd0;
      raw_msg_r     <= 7'd0;
      sigma1_r      <= 4'd0;
      sigma2_r      <= 4'd0;
      exp_deg_r     <= 2'd0;
      fail_flag_r   <= 1'b0;
      chien_cnt_r   <= 4'd0;
      root_cnt_r    <= 2'd0;
      out_msg_r     <= 7'd0;
      out_err_cnt_r <= 2'd0;
      out_unc_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_RECV: begin
          if (accept_s) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            s1_r      <= gf_mul(s1_r, 4'd2) ^ {3'd0, bus.in_bit};
            s3_r      <= gf_mul(s3_r, 4'd8) ^ {3'd0, bus.in_bit};
            word_r    <= {word_r[13:0], bus.in_bit};
          end
        end
        ST_SIGMA: begin
          sigma1_r    <= s1_r;
          sigma2_r    <= sigma2_s;
          exp_deg_r   <= exp_deg_s;
          fail_flag_r <= fail_flag_s;
          raw_msg_r   <= word_r[14:8];
          chien_cnt_r <= 4'd0;
          root_cnt_r  <= 2'd0;
        end
        ST_CHIEN: begin
          word_r      <= word_fix_s;
          root_cnt_r  <= root_cnt_next_s;
          chien_cnt_r <= chien_cnt_r + 4'd1;
          if (chien_cnt_r == 4'd14) begin
            out_unc_r <= unc_s;
            if (unc_s) begin
              out_msg_r     <= raw_msg_r;
              out_err_cnt_r <= 2'd0;
            end else begin
              out_msg_r     <= word_fix_s[14:8];
              out_err_cnt_r <= root_cnt_next_s;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            bit_cnt_r   <= 4'd0;
            s1_r        <= 4'd0;
            s3_r        <= 4'd0;
            root_cnt_r  <= 2'd0;
            chien_cnt_r <= 4'd0;
          end
        end
        default: begin
          bit_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign bus.in_ready          = in_ready_r;
  assign bus.out_valid         = out_valid_r;
  assign bus.out_msg           = out_msg_r;
  assign bus.out_err_cnt       = out_err_cnt_r;
  assign bus.out_uncorrectable = out_unc_r;

endmodule

// File: tb/tb_bch_serial_decoder_15_7.sv
// Self-checking bench for bch_serial_decoder_15_7: directed vector table,
// randomized codewords with injected errors against a nearest-codeword
// reference, and hand-written reset/stall/back-to-back sequences.
module tb_bch_serial_decoder_15_7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bch_serial_decoder_15_7_if bus();

  bch_serial_decoder_15_7 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [14:0] word;
    logic [6:0]  msg;
    logic [1:0]  cnt;
    logic        unc;
    bit          gaps;
    int          stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Codeword for information polynomial k: k(x) * g(x), g = 0x1D1.
  function automatic logic [14:0] encode(input logic [6:0] k);
    logic [14:0] acc;
    acc = 15'd0;
    for (int i = 0; i < 7; i++) begin
      if (k[i]) acc = acc ^ (15'h01D1 << i);
    end
    return acc;
  endfunction

  // Bounded-distance reference: a t=2 decoder returns the unique codeword
  // within Hamming distance 2, otherwise declares failure.
  task automatic model(input logic [14:0] r, output logic [6:0] msg,
                       output logic [1:0] cnt, output logic unc);
    logic [14:0] c;
    int d;
    unc = 1'b1;
    msg = r[14:8];
    cnt = 2'd0;
    for (int k = 0; k < 128; k++) begin
      c = encode(7'(k));
      d = $countones(c ^ r);
      if (d <= 2) begin
        unc = 1'b0;
        msg = c[14:8];
        cnt = 2'(d);
      end
    end
  endtask

  task automatic send_word(input logic [14:0] w, input bit gaps);
    int g;
    for (int i = 14; i >= 0; i--) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          bus.in_valid = 1'b0;
          bus.in_bit   = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      check("in_ready_recv", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_bit   = w[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  // Send a word, wait for the result, check latency/content/stall, then ack.
  // A stray in_valid bit is presented in the ack cycle and must be ignored.
  task automatic run_word(input logic [14:0] w, input bit gaps, input int stall,
                          input logic [6:0] emsg, input logic [1:0] ecnt, input logic eunc);
    int lat;
    bit rdy_seen;
    send_word(w, gaps);
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 17);
    check("in_ready_busy", rdy_seen, 0);
    check("out_msg", bus.out_msg, emsg);
    check("out_err_cnt", bus.out_err_cnt, ecnt);
    check("out_uncorrectable", bus.out_uncorrectable, eunc);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_msg", bus.out_msg, emsg);
      check("stall_cnt", bus.out_err_cnt, ecnt);
      check("stall_unc", bus.out_uncorrectable, eunc);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    check("ack_valid_low", bus.out_valid, 0);
    check("ack_in_ready", bus.in_ready, 1);
    check("hold_msg", bus.out_msg, emsg);
  endtask

  initial begin
    logic [14:0] cw;
    logic [14:0] rw;
    logic [6:0]  mmsg;
    logic [1:0]  mcnt;
    logic        munc;
    int nerr;
    int vcount;
    vec_t v;

    vecs.push_back('{15'h01D1, 7'h01, 2'd0, 1'b0, 1'b0, 0});
    vecs.push_back('{15'h00D1, 7'h01, 2'd1, 1'b0, 1'b0, 0});
    vecs.push_back('{15'h4008, 7'h00, 2'd2, 1'b0, 1'b0, 0});
    vecs.push_back('{15'h0007, 7'h22, 2'd2, 1'b0, 1'b0, 0});
    vecs.push_back('{15'h0000, 7'h00, 2'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{15'h01D0, 7'h01, 2'd1, 1'b0, 1'b1, 0});
    vecs.push_back('{15'h41D1, 7'h01, 2'd1, 1'b0, 1'b0, 2});
    vecs.push_back('{15'h01D1, 7'h01, 2'd0, 1'b0, 1'b1, 5});
    vecs.push_back('{15'h4008, 7'h00, 2'd2, 1'b0, 1'b1, 5});

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_msg", bus.out_msg, 0);
    check("rst_out_err_cnt", bus.out_err_cnt, 0);
    check("rst_out_unc", bus.out_uncorrectable, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      v = vecs[i];
      run_word(v.word, v.gaps, v.stall, v.msg, v.cnt, v.unc);
    end

    // Randomized codewords with 0..4 injected errors
    for (int n = 0; n < 24; n++) begin
      cw = encode(7'($urandom_range(0, 127)));
      rw = cw;
      nerr = $urandom_range(0, 4);
      for (int e = 0; e < nerr; e++) begin
        rw[$urandom_range(0, 14)] ^= 1'b1;
      end
      model(rw, mmsg, mcnt, munc);
      run_word(rw, 1'($urandom_range(0, 1)), $urandom_range(0, 5), mmsg, mcnt, munc);
    end

    // Reset after 9 bits discards the partial word
    for (int i = 14; i >= 6; i--) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midword_rst_in_ready", bus.in_ready, 1);
    check("midword_rst_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_word(15'h01D1, 1'b0, 0, 7'h01, 2'd0, 1'b0);
    vcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check("single_valid_after_rst", vcount, 0);

    // Reset in the middle of the Chien search
    send_word(15'h00D1, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check("chien_rst_no_valid", vcount, 0);
    check("chien_rst_in_ready", bus.in_ready, 1);
    run_word(15'h0007, 1'b1, 3, 7'h22, 2'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bch_serial_decoder_15_7.md
BCH_SERIAL_DECODER_15_7 -- requirements
Module: bch_serial_decoder_15_7

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  in_bit carries a valid codeword bit.
REQ-005 in_bit  input  1  serial codeword bit, c14 first, c0 last.
REQ-006 in_ready  output  1  decoder accepts a bit this cycle.
REQ-007 out_valid  output  1  decoded result available.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_msg  output  7  corrected message; out_msg[6:0] = c14..c8.
REQ-010 out_err_cnt  output  2  number of bits corrected (0..2).
REQ-011 out_uncorrectable  output  1  decode failure flag.

Function
REQ-012 Code SHALL be BCH(15,7,2): generator 9'b111010001; GF(16) primitive polynomial x^4+x+1 (alpha^4 = 4'd3).
REQ-013 FSM SHALL have the states RECV, SIGMA, CHIEN and DONE; reset enters RECV.
REQ-014 RECV: in_ready=1; a bit is accepted when in_valid&&in_ready; the 4-bit counter increments per accepted bit; the counter and syndromes hold when in_valid=0.
REQ-015 Per accepted bit b, the decoder SHALL update S1 <= S1*alpha ^ b and S3 <= S3*alpha^3 ^ b (Horner form), and shift b into a 15-bit word register.
REQ-016 The 15th accepted bit SHALL move the FSM to SIGMA; in_ready=0 in all states other than RECV.
REQ-017 SIGMA (1 cycle): sigma1=S1; sigma2=(S3^S1^3)/S1 when S1!=0, else 0; expected degree = 0 if S1=S3=0, 1 if S1!=0 and S3=S1^3, 2 if S1!=0 otherwise; S1=0 with S3!=0 SHALL set the uncorrectable flag.
REQ-018 CHIEN (15 cycles, j=0..14, one per cycle): evaluate L(alpha^-j)=1^sigma1*alpha^-j^sigma2*alpha^-2j; on zero, toggle word bit j and increment the root count (saturating at 3).
REQ-019 Entering DONE: uncorrectable = flag | (root count != expected degree).
REQ-020 When uncorrectable, out_msg SHALL equal the received bits c14..c8 uncorrected and out_err_cnt SHALL be 0; otherwise out_msg = corrected bits [14:8] and out_err_cnt = root count.
REQ-021 The last bit accepted in cycle T SHALL give SIGMA in T+1, CHIEN in T+2..T+16, and out_valid=1 from T+17; latency is fixed and independent of the error count.
REQ-022 DONE: out_valid=1; out_msg, out_err_cnt and out_uncorrectable SHALL be stable until out_valid&&out_ready; the FSM then enters RECV the next cycle with the counter, S1, S3 and the root count cleared.
REQ-023 Back-to-back words: the first bit of the next word SHALL NOT be accepted in the out_ready handshake cycle.
REQ-024 out_valid=0 and outputs SHALL hold their last values in RECV, SIGMA and CHIEN.
REQ-025 GF multiply and inverse SHALL use log/antilog tables; the log of 0 SHALL never be used as an operand, and zero operands SHALL be handled explicitly.

Reset
REQ-026 On rst: state=RECV, counter=0, S1=S3=0, word=0, in_ready=1, out_valid=0, out_msg=0, out_err_cnt=0, out_uncorrectable=0.
REQ-027 Reset asserted mid-word or mid-CHIEN SHALL discard the partial word; no out_valid for it.
REQ-028 The first bit after reset deassertion SHALL be treated as c14.

Verification
REQ-029 Stream 15'h01D1 continuously -> out_valid at T+17, out_msg=7'h01, out_err_cnt=0, out_uncorrectable=0.
REQ-030 Stream 15'h00D1 (c8 flipped) -> out_msg=7'h01, out_err_cnt=1, out_uncorrectable=0.
REQ-031 Stream 15'h4008 (all-zero codeword, c14 and c3 flipped) -> out_msg=7'h00, out_err_cnt=2, out_uncorrectable=0.
REQ-032 Stream 15'h0007 (3 errors) -> out_msg=7'h22, out_err_cnt=2, out_uncorrectable=0 (documented miscorrection beyond t=2).
REQ-033 Apply random in_valid gaps and hold out_ready=0 for 5 cycles -> results identical to gap-free runs; outputs stable while stalled; in_ready=0 until the handshake completes.
REQ-034 Assert rst after 9 bits, then stream 15'h01D1 -> exactly one out_valid, with out_msg=7'h01.
